riscv_lsu_ctrl: RTL and testbench

Load/store unit controller between the core datapath and the data-memory port. It receives mem_req/mem_we/mem_size from the instruction decoder plus the ALU address and rs2 data. It stalls the core while a transaction is outstanding. It generates byte enables and store-data replication, and sign- or zero-extends load data. It also detects misaligned, illegal-size and timed-out accesses.

---
 rtl/riscv_pkg.sv | 49 ++++
 rtl/lsu_data_align.sv | 49 ++++
 rtl/riscv_lsu_ctrl.sv | 130 +++++++++++++
 tb/tb_riscv_lsu_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: load/store size encodings and LSU types.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = XLEN / 8;

  localparam logic [2:0] LDST_B  = 3'b000;
  localparam logic [2:0] LDST_H  = 3'b001;
  localparam logic [2:0] LDST_W  = 3'b010;
  localparam logic [2:0] LDST_BU = 3'b100;
  localparam logic [2:0] LDST_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'b00,
    LSU_BUSY = 2'b01,
    LSU_RESP = 2'b10
  } lsu_state_t;

  localparam logic [1:0] LSU_ERR_NONE     = 2'b00;
  localparam logic [1:0] LSU_ERR_MISALIGN = 2'b01;
  localparam logic [1:0] LSU_ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] LSU_ERR_SIZE     = 2'b11;

  // Access fields captured when a request is accepted.
  typedef struct packed {
    logic            we;
    logic [2:0]      size;
    logic [XLEN-1:0] addr;
    logic [BE_W-1:0] be;
    logic [XLEN-1:0] wd;
  } lsu_req_t;

  // Stores only have B/H/W; loads additionally have BU/HU.
  function automatic logic lsu_size_illegal(input logic we, input logic [2:0] size);
    if (we) begin
      return !(size == LDST_B || size == LDST_H || size == LDST_W);
    end
    return (size == 3'b011 || size == 3'b110 || size == 3'b111);
  endfunction

  function automatic logic lsu_misaligned(input logic [2:0] size, input logic [1:0] off);
    case (size)
      LDST_H, LDST_HU: return off[0];
      LDST_W:          return (off != 2'b00);
      default:         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Byte-lane steering: store byte enables/replication and load extension.
module lsu_data_align
  import riscv_pkg::*;
(
  input  logic [2:0]      st_size_i,
  input  logic [1:0]      st_off_i,
  input  logic [XLEN-1:0] st_wd_i,
  output logic [BE_W-1:0] st_be_o,
  output logic [XLEN-1:0] st_wd_o,
  input  logic [2:0]      ld_size_i,
  input  logic [1:0]      ld_off_i,
  input  logic [XLEN-1:0] ld_rd_i,
  output logic [XLEN-1:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_be_o = 4'b1111;
    st_wd_o = st_wd_i;
    case (st_size_i)
      LDST_B, LDST_BU: begin
        st_be_o = 4'b0001 << st_off_i;
        st_wd_o = {4{st_wd_i[7:0]}};
      end
      LDST_H, LDST_HU: begin
        st_be_o = 4'b0011 << {st_off_i[1], 1'b0};
        st_wd_o = {2{st_wd_i[15:0]}};
      end
      default: ;
    endcase
  end

  assign ld_byte = ld_rd_i[{ld_off_i, 3'b000} +: 8];
  assign ld_half = ld_rd_i[{ld_off_i[1], 4'b0000} +: 16];

  always_comb begin
    ld_data_o = ld_rd_i;
    case (ld_size_i)
      LDST_B:  ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      LDST_BU: ld_data_o = {24'h000000, ld_byte};
      LDST_H:  ld_data_o = {{16{ld_half[15]}}, ld_half};
      LDST_HU: ld_data_o = {16'h0000, ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/riscv_lsu_ctrl.sv
// Load/store controller: stalls the core around one memory transaction and
// reports misaligned, illegal-size and timed-out accesses.
module riscv_lsu_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            core_req_i,
  input  logic            core_we_i,
  input  logic [2:0]      core_size_i,
  input  logic [XLEN-1:0] core_addr_i,
  input  logic [XLEN-1:0] core_wd_i,
  output logic [XLEN-1:0] core_rd_o,
  output logic            core_stall_o,
  output logic            err_o,
  output logic [1:0]      err_cause_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [BE_W-1:0] mem_be_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wd_o,
  input  logic [XLEN-1:0] mem_rd_i,
  input  logic            mem_ready_i
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_t      state_q, state_d;
  lsu_req_t        req_q, req_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] rd_q, rd_d;
  logic [1:0]      cause_q, cause_d;

  logic [BE_W-1:0] st_be_c;
  logic [XLEN-1:0] st_wd_c;
  logic [XLEN-1:0] ld_data_c;
  logic            busy_c;
  logic            resp_c;

  lsu_data_align u_align (
    .st_size_i (core_size_i),
    .st_off_i  (core_addr_i[1:0]),
    .st_wd_i   (core_wd_i),
    .st_be_o   (st_be_c),
    .st_wd_o   (st_wd_c),
    .ld_size_i (req_q.size),
    .ld_off_i  (req_q.addr[1:0]),
    .ld_rd_i   (mem_rd_i),
    .ld_data_o (ld_data_c)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= LSU_IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
      rd_q    <= '0;
      cause_q <= LSU_ERR_NONE;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    cause_d = cause_q;
    case (state_q)
      LSU_IDLE: begin
        if (core_req_i) begin
          rd_d = '0;
          // Size check wins over alignment when both are wrong.
          if (lsu_size_illegal(core_we_i, core_size_i)) begin
            cause_d = LSU_ERR_SIZE;
            state_d = LSU_RESP;
          end else if (lsu_misaligned(core_size_i, core_addr_i[1:0])) begin
            cause_d = LSU_ERR_MISALIGN;
            state_d = LSU_RESP;
          end else begin
            req_d   = '{we: core_we_i, size: core_size_i, addr: core_addr_i,
                        be: st_be_c, wd: st_wd_c};
            cnt_d   = '0;
            cause_d = LSU_ERR_NONE;
            state_d = LSU_BUSY;
          end
        end
      end
      LSU_BUSY: begin
        if (mem_ready_i) begin
          if (!req_q.we) begin
            rd_d = ld_data_c;
          end
          state_d = LSU_RESP;
        end else if (cnt_q == CNT_LAST) begin
          cause_d = LSU_ERR_TIMEOUT;
          state_d = LSU_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      LSU_RESP: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  assign busy_c = (state_q == LSU_BUSY);
  assign resp_c = (state_q == LSU_RESP);

  assign mem_req_o   = busy_c;
  assign mem_we_o    = busy_c && req_q.we;
  assign mem_be_o    = busy_c ? req_q.be : '0;
  assign mem_addr_o  = {req_q.addr[XLEN-1:2], 2'b00};
  assign mem_wd_o    = req_q.wd;

  assign core_rd_o   = resp_c ? rd_q : '0;
  assign err_o       = resp_c && (cause_q != LSU_ERR_NONE);
  assign err_cause_o = resp_c ? cause_q : LSU_ERR_NONE;
  // Gated by reset so the core is released immediately while rst_ni is low.
  assign core_stall_o = rst_ni && core_req_i && !resp_c;

endmodule

// File: tb/tb_riscv_lsu_ctrl.sv
// Directed-vector bench for riscv_lsu_ctrl with a short timeout.
module tb_riscv_lsu_ctrl;
  import riscv_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        core_req_i;
  logic        core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_o;
  logic        err_o;
  logic [1:0]  err_cause_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;

  int n_vec  = 0;
  int n_miss = 0;

  riscv_lsu_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .core_req_i   (core_req_i),
    .core_we_i    (core_we_i),
    .core_size_i  (core_size_i),
    .core_addr_i  (core_addr_i),
    .core_wd_i    (core_wd_i),
    .core_rd_o    (core_rd_o),
    .core_stall_o (core_stall_o),
    .err_o        (err_o),
    .err_cause_o  (err_cause_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wd_o     (mem_wd_o),
    .mem_rd_i     (mem_rd_i),
    .mem_ready_i  (mem_ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Result of one access as seen from the core and memory sides.
  int          r_stalls;
  logic [31:0] r_rd;
  logic [1:0]  r_cause;
  logic        r_err;
  logic        r_saw_req;
  logic [3:0]  r_be;
  logic [31:0] r_wd;
  logic [31:0] r_addr;
  logic        r_we;

  // Issue one request; memory answers after 'waits' BUSY cycles without ready.
  task automatic run_access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] rdata, input int waits);
    int busy_n = 0;
    bit done = 1'b0;
    r_stalls = 0; r_rd = '0; r_cause = '0; r_err = 1'b0;
    r_saw_req = 1'b0; r_be = '0; r_wd = '0; r_addr = '0; r_we = 1'b0;
    @(negedge clk_i);
    core_req_i = 1'b1; core_we_i = we; core_size_i = size;
    core_addr_i = addr; core_wd_i = wd; mem_ready_i = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (i > 0) @(negedge clk_i);
      #1;
      if (core_stall_o) r_stalls++;
      if (mem_req_o) begin
        r_saw_req = 1'b1; r_be = mem_be_o; r_wd = mem_wd_o;
        r_addr = mem_addr_o; r_we = mem_we_o;
        mem_ready_i = (busy_n == waits);
        mem_rd_i = rdata;
        busy_n++;
      end else begin
        mem_ready_i = 1'b0;
      end
      if (!core_stall_o) begin
        r_rd = core_rd_o; r_err = err_o; r_cause = err_cause_o;
        done = 1'b1;
        core_req_i = 1'b0;
      end
    end
    check_eq("resp_reached", 32'(done), 32'd1);
  endtask

  initial begin
    rst_ni = 1'b0; core_req_i = 1'b0; core_we_i = 1'b0; core_size_i = 3'b000;
    core_addr_i = '0; core_wd_i = '0; mem_rd_i = '0; mem_ready_i = 1'b0;
    #12;
    check_eq("rst_mem_req", 32'(mem_req_o), 32'd0);
    check_eq("rst_stall", 32'(core_stall_o), 32'd0);
    check_eq("rst_rd", core_rd_o, 32'd0);
    check_eq("rst_err", {29'd0, err_o, err_cause_o}, 32'd0);
    check_eq("rst_be", 32'(mem_be_o), 32'd0);
    @(negedge clk_i); rst_ni = 1'b1;

    // LW zero-wait
    run_access(1'b0, LDST_W, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    check_eq("lw_stalls", 32'(r_stalls), 32'd2);
    check_eq("lw_rd", r_rd, 32'hDEADBEEF);
    check_eq("lw_be", 32'(r_be), 32'hF);
    check_eq("lw_addr", r_addr, 32'h100);
    check_eq("lw_we", 32'(r_we), 32'd0);
    check_eq("lw_err", 32'(r_err), 32'd0);
    check_eq("lw_addr_resp", mem_addr_o, 32'h100);

    // LB / LBU on the top byte lane
    run_access(1'b0, LDST_B, 32'h103, 32'h0, 32'h80FFFFFF, 0);
    check_eq("lb_rd", r_rd, 32'hFFFFFF80);
    check_eq("lb_be", 32'(r_be), 32'h8);
    check_eq("lb_addr", r_addr, 32'h100);
    run_access(1'b0, LDST_BU, 32'h103, 32'h0, 32'h80FFFFFF, 0);
    check_eq("lbu_rd", r_rd, 32'h00000080);

    // SH upper half
    run_access(1'b1, LDST_H, 32'h202, 32'h1234ABCD, 32'hFFFFFFFF, 0);
    check_eq("sh_we", 32'(r_we), 32'd1);
    check_eq("sh_be", 32'(r_be), 32'hC);
    check_eq("sh_wd", r_wd, 32'hABCDABCD);
    check_eq("sh_addr", r_addr, 32'h200);
    check_eq("sh_err", 32'(r_err), 32'd0);
    check_eq("sh_rd", r_rd, 32'd0);

    // SB lane 1
    run_access(1'b1, LDST_B, 32'h301, 32'h000000A5, 32'h0, 0);
    check_eq("sb_be", 32'(r_be), 32'h2);
    check_eq("sb_wd", r_wd, 32'hA5A5A5A5);

    // Misaligned LW
    run_access(1'b0, LDST_W, 32'h101, 32'h0, 32'h12345678, 0);
    check_eq("mis_req", 32'(r_saw_req), 32'd0);
    check_eq("mis_err", 32'(r_err), 32'd1);
    check_eq("mis_cause", 32'(r_cause), 32'(LSU_ERR_MISALIGN));
    check_eq("mis_stalls", 32'(r_stalls), 32'd1);
    check_eq("mis_rd", r_rd, 32'd0);

    // Illegal store size
    run_access(1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 0);
    check_eq("ill_cause", 32'(r_cause), 32'(LSU_ERR_SIZE));
    check_eq("ill_req", 32'(r_saw_req), 32'd0);
    // Illegal store size that is also misaligned: size takes priority
    run_access(1'b1, LDST_HU, 32'h101, 32'h0, 32'h0, 0);
    check_eq("both_cause", 32'(r_cause), 32'(LSU_ERR_SIZE));
    // Illegal load size
    run_access(1'b0, 3'b111, 32'h100, 32'h0, 32'h0, 0);
    check_eq("ill_ld_cause", 32'(r_cause), 32'(LSU_ERR_SIZE));

    // Timeout with ready never asserted
    run_access(1'b0, LDST_W, 32'h400, 32'h0, 32'hCAFEF00D, 1000);
    check_eq("to_stalls", 32'(r_stalls), 32'd5);
    check_eq("to_cause", 32'(r_cause), 32'(LSU_ERR_TIMEOUT));
    check_eq("to_err", 32'(r_err), 32'd1);
    check_eq("to_rd", r_rd, 32'd0);

    // Two wait cycles: 5-cycle access, halfword extension of upper lane
    run_access(1'b0, LDST_HU, 32'h102, 32'h0, 32'hBEEF1234, 2);
    check_eq("hu_stalls", 32'(r_stalls), 32'd4);
    check_eq("hu_rd", r_rd, 32'h0000BEEF);
    check_eq("hu_err", 32'(r_err), 32'd0);
    run_access(1'b0, LDST_H, 32'h102, 32'h0, 32'hBEEF1234, 0);
    check_eq("h_rd", r_rd, 32'hFFFFBEEF);
    check_eq("h_be", 32'(r_be), 32'hC);

    // Reset pulsed while BUSY
    @(negedge clk_i);
    core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = LDST_W;
    core_addr_i = 32'h500; mem_ready_i = 1'b0;
    @(negedge clk_i); #1;
    check_eq("rb_busy_req", 32'(mem_req_o), 32'd1);
    rst_ni = 1'b0; #1;
    check_eq("rb_req_drop", 32'(mem_req_o), 32'd0);
    check_eq("rb_stall_drop", 32'(core_stall_o), 32'd0);
    @(negedge clk_i); rst_ni = 1'b1; core_req_i = 1'b0; #1;
    check_eq("rb_idle_req", 32'(mem_req_o), 32'd0);
    run_access(1'b0, LDST_W, 32'h600, 32'h0, 32'h13579BDF, 0);
    check_eq("rb_lw_stalls", 32'(r_stalls), 32'd2);
    check_eq("rb_lw_rd", r_rd, 32'h13579BDF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
